// File: rtl/ad9363_phy_emu.sv
// AD9363-side emulator of the 12-bit frame/data sample port.
// The TX port (tx_frame/p1_d) is deframed into I/Q pairs and pushed into a
// show-ahead capture FIFO. The RX port (rx_frame/p0_d) is framed from either
// a ramp pattern or, in loopback, from the captured samples.
module ad9363_phy_emu #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16,
    parameter int RAMP_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loopback_en,
    input  logic              tx_frame,
    input  logic [DATA_W-1:0] p1_d,
    output logic              rx_frame,
    output logic [DATA_W-1:0] p0_d,
    output logic              cap_valid,
    output logic [DATA_W-1:0] cap_data_i,
    output logic [DATA_W-1:0] cap_data_q,
    input  logic              cap_ready,
    output logic [CNT_W-1:0]  frame_err_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {D_WAIT_I, D_WAIT_Q} dstate_t;
    typedef enum logic {F_I, F_Q} fstate_t;

    dstate_t             dstate_q, dstate_d;
    fstate_t             fstate_q, fstate_d;
    logic [DATA_W-1:0]   i_lat_q, i_lat_d;
    logic [DATA_W-1:0]   q_lat_q, q_lat_d;
    logic [DATA_W-1:0]   ramp_q, ramp_d;
    logic                rx_frame_q, rx_frame_d;
    logic [DATA_W-1:0]   p0_d_q, p0_d_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [CNT_W-1:0]    ferr_q, ferr_d, ovf_q, ovf_d;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic                empty, full, push, ferr, fr_pop, pop, wr_en, drop;
    logic [2*DATA_W-1:0] head;

    // FIFO status and push/pop decisions for this cycle
    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == (AW+1)'(FIFO_DEPTH));
        head   = mem_q[rd_ptr_q];
        push   = (dstate_q == D_WAIT_Q) && !tx_frame;
        ferr   = (dstate_q == D_WAIT_Q) && tx_frame;
        fr_pop = (fstate_q == F_I) && loopback_en && !empty;
        pop    = loopback_en ? fr_pop : (!empty && cap_ready);
        // a pop in the same cycle frees the slot the push needs
        wr_en  = push && (!full || pop);
        drop   = push && full && !pop;
    end

    // Deframer, FIFO pointers and saturating error counters
    always_comb begin
        dstate_d = dstate_q;
        i_lat_d  = i_lat_q;
        if (tx_frame) begin
            i_lat_d  = p1_d;
            dstate_d = D_WAIT_Q;
        end else if (dstate_q == D_WAIT_Q) begin
            dstate_d = D_WAIT_I;
        end
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!wr_en && pop) count_d = count_q - (AW+1)'(1);
        ferr_d = (ferr && ferr_q != '1) ? ferr_q + CNT_W'(1) : ferr_q;
        ovf_d  = (drop && ovf_q  != '1) ? ovf_q  + CNT_W'(1) : ovf_q;
    end

    // Framer: emits I then Q; loopback_en only matters when starting a sample
    always_comb begin
        fstate_d   = fstate_q;
        q_lat_d    = q_lat_q;
        ramp_d     = ramp_q;
        rx_frame_d = 1'b0;
        p0_d_d     = '0;
        if (fstate_q == F_Q) begin
            p0_d_d   = q_lat_q;
            fstate_d = F_I;
        end else if (!loopback_en) begin
            rx_frame_d = 1'b1;
            p0_d_d     = ramp_q;
            q_lat_d    = ~ramp_q;
            ramp_d     = ramp_q + DATA_W'(RAMP_STEP);
            fstate_d   = F_Q;
        end else if (!empty) begin
            rx_frame_d = 1'b1;
            p0_d_d     = head[2*DATA_W-1:DATA_W];
            q_lat_d    = head[DATA_W-1:0];
            fstate_d   = F_Q;
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dstate_q   <= D_WAIT_I;
            fstate_q   <= F_I;
            i_lat_q    <= '0;
            q_lat_q    <= '0;
            ramp_q     <= '0;
            rx_frame_q <= 1'b0;
            p0_d_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ferr_q     <= '0;
            ovf_q      <= '0;
        end else begin
            dstate_q   <= dstate_d;
            fstate_q   <= fstate_d;
            i_lat_q    <= i_lat_d;
            q_lat_q    <= q_lat_d;
            ramp_q     <= ramp_d;
            rx_frame_q <= rx_frame_d;
            p0_d_q     <= p0_d_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Sample storage; contents are only visible through the non-empty gate
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {i_lat_q, p1_d};
    end

    assign rx_frame      = rx_frame_q;
    assign p0_d          = p0_d_q;
    assign cap_valid     = !loopback_en && !empty;
    assign cap_data_i    = empty ? '0 : head[2*DATA_W-1:DATA_W];
    assign cap_data_q    = empty ? '0 : head[DATA_W-1:0];
    assign frame_err_cnt = ferr_q;
    assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_ad9363_phy_emu.sv
module tb_ad9363_phy_emu;
    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int CW    = 4;   // small counters so saturation is reachable
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          loopback_en = 1'b0, tx_frame = 1'b0, cap_ready = 1'b0;
    logic [DW-1:0] p1_d = '0;
    logic          rx_frame, cap_valid;
    logic [DW-1:0] p0_d, cap_data_i, cap_data_q;
    logic [CW-1:0] frame_err_cnt, ovf_cnt;

    int checks = 0;
    int errors = 0;

    ad9363_phy_emu #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .RAMP_STEP(1)) dut (
        .clk(clk), .rst(rst), .loopback_en(loopback_en), .tx_frame(tx_frame), .p1_d(p1_d),
        .rx_frame(rx_frame), .p0_d(p0_d), .cap_valid(cap_valid), .cap_data_i(cap_data_i),
        .cap_data_q(cap_data_q), .cap_ready(cap_ready), .frame_err_cnt(frame_err_cnt),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // reference model: sample-level view of the port
    logic [2*DW-1:0] fq[$];     // captured samples in arrival order
    logic            have_i;    // an I word is waiting for its Q
    logic [DW-1:0]   i_val;
    logic            q_pending; // next RX word is the Q half
    logic [DW-1:0]   q_val;
    logic [DW-1:0]   ramp;
    int              m_ferr, m_ovf;
    logic            exp_rx;
    logic [DW-1:0]   exp_p0;

    task automatic model_reset();
        fq.delete();
        have_i = 0; i_val = '0; q_pending = 0; q_val = '0; ramp = '0;
        m_ferr = 0; m_ovf = 0; exp_rx = 0; exp_p0 = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // one clock edge of the model, using the inputs held across that edge
    task automatic model_edge(input logic f, input logic [DW-1:0] d, input logic r, input logic lb);
        int  pre = fq.size();
        bit  popped = 0;
        if (q_pending) begin
            exp_rx = 0; exp_p0 = q_val; q_pending = 0;
        end else if (!lb) begin
            exp_rx = 1; exp_p0 = ramp; q_val = ~ramp; ramp = ramp + 1'b1; q_pending = 1;
        end else if (pre > 0) begin
            exp_rx = 1; exp_p0 = fq[0][2*DW-1:DW]; q_val = fq[0][DW-1:0]; q_pending = 1;
            popped = 1;
        end else begin
            exp_rx = 0; exp_p0 = '0;
        end
        if (!lb && r && pre > 0) popped = 1;
        if (popped) void'(fq.pop_front());
        if (f) begin
            if (have_i && m_ferr < CMAX) m_ferr++;
            i_val = d; have_i = 1;
        end else if (have_i) begin
            have_i = 0;
            if (pre < DEPTH || popped) fq.push_back({i_val, d});
            else if (m_ovf < CMAX) m_ovf++;
        end
    endtask

    task automatic check_all(input logic lb);
        bit v = !lb && fq.size() > 0;
        chk("rx_frame", rx_frame, exp_rx);
        chk("p0_d", p0_d, exp_p0);
        chk("cap_valid", cap_valid, v);
        if (v) begin
            chk("cap_data_i", cap_data_i, fq[0][2*DW-1:DW]);
            chk("cap_data_q", cap_data_q, fq[0][DW-1:0]);
        end
        chk("frame_err_cnt", frame_err_cnt, m_ferr);
        chk("ovf_cnt", ovf_cnt, m_ovf);
    endtask

    task automatic step(input logic f, input logic [DW-1:0] d, input logic r, input logic lb);
        tx_frame = f; p1_d = d; cap_ready = r; loopback_en = lb;
        @(posedge clk); #1;
        model_edge(f, d, r, lb);
        check_all(lb);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rx_frame", rx_frame, 0);
        chk("rst_p0_d", p0_d, 0);
        chk("rst_cap_valid", cap_valid, 0);
        chk("rst_ferr", frame_err_cnt, 0);
        chk("rst_ovf", ovf_cnt, 0);
    endtask

    initial begin
        logic lb;
        int   n;
        model_reset();
        // reset state
        @(posedge clk); #1;
        check_reset_outputs();
        @(negedge clk); rst = 1'b1;

        // 1: ramp pattern across a full wrap
        for (int k = 0; k < 2 * 4096 + 8; k++) step(0, '0, 1, 0);

        // 2: one clean sample
        step(1, 12'h123, 1, 0);
        step(0, 12'h456, 1, 0);
        chk("t2_valid", cap_valid, 1);
        chk("t2_i", cap_data_i, 12'h123);
        chk("t2_q", cap_data_q, 12'h456);
        step(0, '0, 1, 0);

        // 3: framing error re-latches I
        step(1, 12'hAAA, 0, 0);
        step(1, 12'hBBB, 0, 0);
        step(0, 12'hCCC, 0, 0);
        chk("t3_ferr", frame_err_cnt, 1);
        chk("t3_i", cap_data_i, 12'hBBB);
        chk("t3_q", cap_data_q, 12'hCCC);
        step(0, '0, 1, 0);

        // 4: overflow by three, then drain
        for (int k = 0; k < DEPTH + 3; k++) begin
            step(1, DW'($urandom), 0, 0);
            step(0, DW'($urandom), 0, 0);
        end
        chk("t4_ovf", ovf_cnt, 3);
        for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0);

        // 5: loopback replay with idle words between
        for (int k = 0; k < 2; k++) step(0, '0, 1, 1);
        step(1, 12'h111, 0, 1);
        step(0, 12'h222, 0, 1);
        for (int k = 0; k < 3; k++) step(0, '0, 0, 1);
        step(1, 12'h333, 0, 1);
        step(0, 12'h444, 0, 1);
        for (int k = 0; k < 5; k++) step(0, '0, 0, 1);

        // counter saturation
        for (int k = 0; k < CMAX + 5; k++) step(1, DW'($urandom), 0, 0);
        step(0, '0, 0, 0);
        chk("sat_ferr", frame_err_cnt, CMAX);
        for (int k = 0; k < DEPTH + CMAX + 4; k++) begin
            step(1, DW'($urandom), 0, 0);
            step(0, DW'($urandom), 0, 0);
        end
        chk("sat_ovf", ovf_cnt, CMAX);
        for (int k = 0; k < DEPTH + 2; k++) step(0, '0, 1, 0);

        // randomized traffic, occasional mode changes
        lb = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) lb = ~lb;
            step(1'($urandom_range(0, 2) == 0), DW'($urandom), 1'($urandom), lb);
        end

        // 6: reset while the framer is mid-sample
        n = 0;
        step(0, '0, 1, 0);
        while (!(exp_rx === 1'b1) && n < 4) begin
            step(0, '0, 1, 0);
            n++;
        end
        chk("t6_in_fq", exp_rx, 1);
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 8; k++) step(0, '0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
